// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: state encoding, default width
// and the MULT/MULTU function codes the decoder maps onto is_signed.
package mult_pkg;

  localparam int unsigned DefWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StSign = 2'd2,
    StDone = 2'd3
  } mult_state_e;

  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;

  function automatic logic funct_is_signed(input logic [5:0] funct);
    return funct == FunctMult;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/result bundle between the ID/EX operand path and the multiplier.
interface mult_seq_if import mult_pkg::*; #(
  parameter int unsigned WIDTH = DefWidth
);
  logic             start;
  logic             flush;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  modport master (
    output start, flush, is_signed, a, b,
    input  busy, done, res_hi, res_lo
  );

  modport slave (
    input  start, flush, is_signed, a, b,
    output busy, done, res_hi, res_lo
  );
endinterface

// File: rtl/mult_acc_add.sv
// Accumulate-step adder: WIDTH-bit sum plus carry-out for the shift-add datapath.
module mult_acc_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier: WIDTH RUN steps on magnitudes, then a SIGN fix-up
// cycle that writes the registered product halves.
module mult_seq import mult_pkg::*; #(
  parameter int unsigned WIDTH = DefWidth
) (
  input logic        clk,
  input logic        rst,
  mult_seq_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [2*WIDTH-1:0] ProdOne = (2*WIDTH)'(1);

  mult_state_e      state_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] res_hi_q, res_lo_q;

  logic [WIDTH-1:0]   addend, sum, a_mag, b_mag;
  logic               carry;
  logic [2*WIDTH-1:0] prod, prod_signed;
  logic               accept;

  assign addend = mplier_q[0] ? mcand_q : '0;

  mult_acc_add #(.WIDTH(WIDTH)) u_add (
    .a_i     (acc_q),
    .b_i     (addend),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? ~bus.a + WIDTH'(1) : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? ~bus.b + WIDTH'(1) : bus.b;

  assign prod        = {acc_q, mplier_q};
  assign prod_signed = neg_q ? ~prod + ProdOne : prod;
  assign accept      = bus.start && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (accept) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            neg_q    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= CntW'(WIDTH - 1);
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q    <= {carry, sum[WIDTH-1:1]};
            mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= StSign;
          end
        end
        StSign: begin
          busy_q <= 1'b0;
          if (bus.flush) begin
            state_q <= StIdle;
          end else begin
            {res_hi_q, res_lo_q} <= prod_signed;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.res_hi = res_hi_q;
  assign bus.res_lo = res_lo_q;
endmodule

// File: tb/tb_mult_seq.sv
// Randomized and directed bench for mult_seq: stimulus pushes expected products,
// a negedge monitor pops and compares them whenever done is seen.
module tb_mult_seq;
  localparam int unsigned W = 32;
  localparam int Lat = 34;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(x * y);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        chk("result", {bus.res_hi, bus.res_lo}, exp_q.pop_front());
      end
    end
  end

  // Caller must be at a negedge; start is sampled at the following posedge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit expect_done);
    bus.a = a; bus.b = b; bus.is_signed = s; bus.start = 1'b1;
    if (expect_done) exp_q.push_back(ref_mul(a, b, s));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.is_signed = 1'($urandom);
  endtask

  // Returns at the negedge of the done cycle; poke_at>0 pulses start during RUN.
  task automatic wait_done(input int poke_at);
    bit busy_ok = 1'b1;
    int lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == poke_at) begin
        bus.start = 1'b1; bus.a = $urandom; bus.b = $urandom;
      end else if (n == poke_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy !== (n <= Lat - 1)) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(Lat));
    chk("busy_profile", 64'(busy_ok), 64'd1);
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    int seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.flush = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_res", {bus.res_hi, bus.res_lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    start_op(32'd3, 32'd5, 1'b0, 1'b1);
    wait_done(0);
    chk("u3x5_direct", {bus.res_hi, bus.res_lo}, 64'h0000_0000_0000_000F);
    @(negedge clk);
    start_op(32'hFFFF_FFF9, 32'd6, 1'b1, 1'b1);
    wait_done(0);
    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done(0);
    chk("umax_direct", {bus.res_hi, bus.res_lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    wait_done(0);
    chk("smin_direct", {bus.res_hi, bus.res_lo}, 64'h4000_0000_0000_0000);

    // Start pulsed mid-RUN must be ignored.
    @(negedge clk);
    start_op(32'd2, 32'd3, 1'b0, 1'b1);
    wait_done(7);
    chk("ignored_start", {bus.res_hi, bus.res_lo}, 64'h6);

    // Back-to-back: launch from the done cycle.
    start_op(32'd2, 32'd3, 1'b0, 1'b1);
    wait_done(0);
    start_op(32'd4, 32'd5, 1'b0, 1'b1);
    wait_done(0);
    chk("b2b_result", {bus.res_hi, bus.res_lo}, 64'h14);

    // Flush in RUN cycle 10.
    @(negedge clk);
    start_op(32'd9, 32'd9, 1'b0, 1'b0);
    for (int n = 1; n <= 10; n++) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_res_hold", {bus.res_hi, bus.res_lo}, 64'h14);
    expect_no_done("flush_no_done", 40);

    // Flush and start together in IDLE: flush wins.
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_beats_start", 64'(bus.busy), 64'd0);
    expect_no_done("flush_start_no_done", 40);

    // Asynchronous reset mid-RUN.
    start_op(32'd11, 32'd13, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_res", {bus.res_hi, bus.res_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_no_done("rst_no_done", 40);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 6 == 1) ra = 32'h8000_0000;
      if (i % 6 == 3) rb = 32'hFFFF_FFFF;
      if (i % 6 == 5) ra = 32'd0;
      start_op(ra, rb, 1'(i % 2), 1'b1);
      wait_done(0);
    end

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle radix-2 shift-add integer multiplier in the execute stage, beside the ALU adder.
- Takes operands from the ID/EX register and returns a 2*WIDTH-bit product to EX/MEM.
- Raises busy so the hazard unit stalls the front end.
- Handles signed (MULT) and unsigned (MULTU) operands.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
flush  input  1  pipeline squash; aborts any operation in progress.
is_signed  input  1  1 = two's-complement operands; 0 = unsigned.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
busy  output  1  high in RUN and SIGN.
done  output  1  one-cycle pulse when res_hi/res_lo become valid.
res_hi  output  WIDTH  upper product half; registered.
res_lo  output  WIDTH  lower product half; registered.

Behaviour:
- Reset:
  - Async, active-high.
  - state=IDLE; busy=0, done=0, res_hi=0, res_lo=0; all internal registers 0.
  - Reset mid-operation abandons the operation and produces no done.
- States: IDLE, RUN, SIGN, DONE.
- IDLE: start=1 and flush=0 at an edge → load and go to RUN.
  - Load: mcand=|a| and mplier=|b| when is_signed, else raw a and b.
  - Load: neg = is_signed & (a[MSB]^b[MSB]); acc=0; cnt=WIDTH-1.
- Magnitudes:
  - |x| = ~x+1 when the MSB is set.
  - -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned WIDTH bits.
- RUN, one step per cycle:
  - Sum = {carry, acc + (mplier[0] ? mcand : 0)}, a (WIDTH+1)-bit sum.
  - Shift {sum, mplier} right by one into {acc, mplier}.
  - cnt decrements; after the cnt==0 step go to SIGN.
  - RUN lasts exactly WIDTH cycles, with no early termination for zero operands.
- SIGN:
  - P = {acc, mplier}; P = neg ? (~P+1) : P, computed mod 2^(2*WIDTH).
  - Write res_hi/res_lo; go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 here is accepted as in IDLE (back-to-back); otherwise go to IDLE.
- Latency:
  - start sampled in cycle 0 → RUN in cycles 1..WIDTH, SIGN in WIDTH+1, done in WIDTH+2 (34 for WIDTH=32).
  - Result is visible on res_hi/res_lo in the done cycle.
- Result hold: res_hi/res_lo change only on the SIGN→DONE edge and hold until the next SIGN or reset. Working registers are separate from the output registers.
- busy: 1 in RUN and SIGN; 0 in IDLE and DONE.
- start while busy is ignored; operands are not re-sampled.
- flush:
  - In RUN or SIGN: next state IDLE, no done pulse, res_* retain their previous values.
  - Simultaneous flush and start in IDLE/DONE: flush wins, start is dropped, next state IDLE.
- Operand changes after the start cycle have no effect.

Decomposition:
- Shared package mult_pkg holds:
  - state encoding: 2-bit IDLE=0, RUN=1, SIGN=2, DONE=3;
  - default WIDTH constant;
  - MULT/MULTU control encodings used by the decoder to drive is_signed.
- One sub-module, mult_acc_add: WIDTH-bit adder with carry-out for the accumulate step.
- Negations use a plain behavioural 2*WIDTH-bit increment.

Test Plan:
- Unsigned 3*5, start in cycle 0 → busy cycles 1..33, done exactly in cycle 34, res_hi=0x00000000, res_lo=0x0000000F.
- Signed -7*6 (a=0xFFFFFFF9, b=0x00000006) → res_hi=0xFFFFFFFF, res_lo=0xFFFFFFD6.
- Extremes:
  - Unsigned 0xFFFFFFFF*0xFFFFFFFF → res_hi=0xFFFFFFFE, res_lo=0x00000001.
  - Signed 0x80000000*0x80000000 → res_hi=0x40000000, res_lo=0x00000000.
- Back-to-back and ignored start:
  - Start in the done cycle of a 2*3 op with 4*5 → second done 34 cycles later, res_lo=0x14.
  - Start pulsed during RUN with different operands → ignored, result still 0x6.
- Abort cases:
  - flush in RUN cycle 10 → busy=0 next cycle, no done, res_* keep the prior value 0x14.
  - rst asserted asynchronously mid-RUN → all outputs 0 immediately, state IDLE.
